prio_req_issuer: RTL

Sequential transmit-side companion to the combinational priority-select datapath: it accepts an 8-bit request vector plus per-request data bits, then issues the requests one at a time, lowest index first, as one-hot grants over a valid/ready handshake. It replaces the single-shot "first set bit wins" selection with a full drain of every set request, and reports a completion pulse and grant count. It sits between the request source and the downstream consumer of one-hot select/data pairs.

---
 rtl/prio_req_issuer_if.sv | 30 +++
 rtl/prio_req_issuer.sv | 98 +++++++++
 2 files changed

// File: rtl/prio_req_issuer_if.sv
// Request-load / grant-issue bus between the request source and the priority issuer.
// The master is the request source and grant consumer; the slave is the issuer.
interface prio_req_issuer_if #(
  parameter int N  = 8,
  parameter int IW = 3,
  parameter int CW = 4
);
  logic          load;
  logic [N-1:0]  req_in;
  logic [N-1:0]  dat_in;
  logic          abort;
  logic          gnt_vld;
  logic          gnt_rdy;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_dat;
  logic          busy;
  logic          done;
  logic [CW-1:0] gnt_cnt;

  modport master (
    output load, req_in, dat_in, abort, gnt_rdy,
    input  gnt_vld, gnt, gnt_idx, gnt_dat, busy, done, gnt_cnt
  );

  modport slave (
    input  load, req_in, dat_in, abort, gnt_rdy,
    output gnt_vld, gnt, gnt_idx, gnt_dat, busy, done, gnt_cnt
  );
endinterface

// File: rtl/prio_req_issuer.sv
// Drains a captured request vector one grant at a time, lowest index first,
// over a valid/ready handshake; reports a done pulse and the accepted-grant count.
module prio_req_issuer #(
  parameter int N  = 8,
  parameter int IW = 3,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_req_issuer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_pend, w_pend_nxt;
  logic [N-1:0]  r_data, w_data_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]  w_low;
  logic [IW-1:0] w_idx;
  logic          w_issue;
  logic          w_hs;

  function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IW'(i);
    end
    return idx;
  endfunction

  // Isolate the lowest set pending bit (two's-complement trick).
  assign w_low   = r_pend & (~r_pend + {{(N-1){1'b0}}, 1'b1});
  assign w_idx   = onehot_to_idx(w_low);
  assign w_issue = (r_state == S_ISSUE);
  assign w_hs    = w_issue && bus.gnt_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // abort outranks load even though abort alone does nothing here
        if (bus.load && !bus.abort) begin
          w_pend_nxt  = bus.req_in;
          w_data_nxt  = bus.dat_in;
          w_cnt_nxt   = '0;
          w_state_nxt = (|bus.req_in) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          w_pend_nxt = r_pend & ~w_low;
          w_cnt_nxt  = r_cnt + 1'b1;
          if ((r_pend & ~w_low) == '0) w_state_nxt = S_DONE;
        end
        if (bus.abort) begin
          w_pend_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (bus.abort) w_pend_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pend_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.gnt_vld = w_issue;
  assign bus.gnt     = w_issue ? w_low : '0;
  assign bus.gnt_idx = w_issue ? w_idx : '0;
  assign bus.gnt_dat = w_issue & r_data[w_idx];
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.gnt_cnt = r_cnt;

endmodule
